// File: rtl/snake_tick_scheduler.sv
// Game-speed scheduler: turns clk into one-shot movement requests whose period
// shrinks with level, with start/pause/game-over sequencing and a req/ack handshake.
module snake_tick_scheduler #(
   parameter int unsigned BASE_PERIOD    = 50_000_000,
   parameter int unsigned FOOD_PER_LEVEL = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [2:0] i_init_level,
   input  logic       i_pause_tgl,
   input  logic       i_game_over,
   input  logic       i_food_eaten,
   input  logic       i_move_ack,
   output logic       o_move_req,
   output logic [2:0] o_level,
   output logic [1:0] o_state,
   output logic [7:0] o_overrun_cnt
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StOver  = 2'd3
   } state_e;

   state_e      r_state;
   logic [31:0] r_cnt;
   logic [31:0] r_cur_period;
   logic [2:0]  r_level;
   logic [7:0]  r_food;
   logic        r_move_req;
   logic [7:0]  r_overrun;

   logic        w_tick;
   logic        w_food_wrap;
   logic [7:0]  w_food_nxt;
   logic [2:0]  w_level_nxt;

   // Deep levels can shift a small base period to zero; clamp so a tick still fires.
   function automatic logic [31:0] period_for(input logic [2:0] lvl);
      logic [31:0] p;
      p = BASE_PERIOD >> lvl;
      if (p == 32'd0) begin
         p = 32'd1;
      end
      return p;
   endfunction

   always_comb begin
      w_tick      = (r_state == StRun) && (r_cnt == r_cur_period - 32'd1);
      w_food_wrap = (r_food == 8'(FOOD_PER_LEVEL - 1));
      w_food_nxt  = r_food;
      w_level_nxt = r_level;
      if ((r_state == StRun) && i_food_eaten) begin
         if (w_food_wrap) begin
            w_food_nxt = 8'd0;
            if (r_level != 3'd7) begin
               w_level_nxt = r_level + 3'd1;
            end
         end else begin
            w_food_nxt = r_food + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_cnt        <= 32'd0;
         r_cur_period <= 32'(BASE_PERIOD);
         r_level      <= 3'd0;
         r_food       <= 8'd0;
         r_move_req   <= 1'b0;
         r_overrun    <= 8'd0;
      end else begin
         unique case (r_state)
            StIdle, StOver: begin
               r_move_req <= 1'b0;
               r_cnt      <= 32'd0;
               if (i_start) begin
                  r_state      <= StRun;
                  r_level      <= i_init_level;
                  r_food       <= 8'd0;
                  r_overrun    <= 8'd0;
                  r_cur_period <= period_for(i_init_level);
               end
            end
            StRun: begin
               if (i_game_over) begin
                  r_state    <= StOver;
                  r_move_req <= 1'b0;
                  r_cnt      <= 32'd0;
               end else begin
                  // Pause lands next cycle; this cycle's count, tick and food still apply.
                  if (i_pause_tgl) begin
                     r_state <= StPause;
                  end
                  r_food  <= w_food_nxt;
                  r_level <= w_level_nxt;
                  if (w_tick) begin
                     r_cnt        <= 32'd0;
                     r_cur_period <= period_for(w_level_nxt);
                     r_move_req   <= 1'b1;
                     if (r_move_req && !i_move_ack && (r_overrun != 8'hFF)) begin
                        r_overrun <= r_overrun + 8'd1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                     if (i_move_ack) begin
                        r_move_req <= 1'b0;
                     end
                  end
               end
            end
            StPause: begin
               if (i_game_over) begin
                  r_state    <= StOver;
                  r_move_req <= 1'b0;
                  r_cnt      <= 32'd0;
               end else begin
                  if (i_pause_tgl) begin
                     r_state <= StRun;
                  end
                  if (i_move_ack) begin
                     r_move_req <= 1'b0;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_move_req    = r_move_req;
   assign o_level       = r_level;
   assign o_state       = r_state;
   assign o_overrun_cnt = r_overrun;

endmodule

// File: doc/snake_tick_scheduler.md
# snake_tick_scheduler

Game-speed scheduler for the snake core. It turns the system clock into one-shot movement requests whose period shrinks as the snake eats. It handles start, pause and game-over sequencing, and hands each movement step to the game logic through a req/ack handshake. It replaces the free-running fixed 1 s toggle as the source of game ticks.

## Interface
Parameters:
- BASE_PERIOD, 50_000_000: tick period in clk cycles at level 0. Must be ≥ 256 in silicon; benches use 16.
- FOOD_PER_LEVEL, 4: food pulses needed per level increment. Range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- init_level  in  3  starting speed level, sampled on an accepted start.
- pause_tgl  in  1  one-cycle pulse; toggles RUN ↔ PAUSE.
- game_over  in  1  one-cycle pulse from game logic; ends the game.
- food_eaten  in  1  one-cycle pulse; counts toward speed-up.
- move_ack  in  1  game logic has consumed the pending move.
- move_req  out  1  a move step is pending; held until acked.
- level  out  3  current speed level, 0..7.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- overrun_cnt  out  8  ticks lost because a request was still pending; saturates at 255.

## Operation
- Period for level L is BASE_PERIOD >> L. It is computed in 32 bits and latched into `cur_period` at game start and at every tick wrap.
- A level change takes effect from the next period, never mid-period.

State transitions:
- **IDLE:** start → RUN. On entry to RUN: cnt=0, level=init_level, food counter=0, overrun_cnt=0, move_req=0, `cur_period` latched.
- **RUN:** cnt increments each cycle. At cnt==cur_period-1 a tick fires, cnt←0 and `cur_period` is relatched.
  - game_over → OVER.
  - pause_tgl → PAUSE.
  - start is ignored.
- **PAUSE:** cnt frozen and no ticks fire. A pending move_req stays high and move_ack still clears it. food_eaten is ignored.
  - pause_tgl → RUN; counting resumes from the frozen value.
  - game_over → OVER.
- **OVER:** move_req←0, cnt←0. level and overrun_cnt hold for display. start → RUN, with the same initialisation as from IDLE.

Tick handling:
- move_req=0 → move_req←1.
- move_req=1 with move_ack=1 in the same cycle → move_req stays 1 (the new move replaces the acked one). No overrun is counted.
- move_req=1 with move_ack=0 → move_req stays 1 and overrun_cnt increments, saturating at 255.
- move_ack with no tick → move_req←0. move_ack while move_req=0 is ignored.

Speed-up:
- food_eaten in RUN increments the food counter.
- When the counter reaches FOOD_PER_LEVEL-1 and food_eaten=1, the counter resets to 0 and level increments, saturating at 7.
- At level 7 the counter still wraps but level holds.

Priority within one cycle (RUN): game_over > pause_tgl > tick and food.
- A tick coinciding with pause_tgl still fires; the pause takes effect from the next cycle.
- game_over suppresses a coincident tick.

Reset (rst_n=0, asynchronous): state=IDLE, move_req=0, level=0, overrun_cnt=0, cnt=0, food counter=0, `cur_period`=BASE_PERIOD.

## Timing
- Start → first move_req: start is accepted at edge 0. move_req rises at edge cur_period; the first tick is a full period after start.
- Tick → move_req high: one registered cycle. Subsequent ticks are exactly cur_period cycles apart while in RUN.
- move_ack → move_req low: next edge.
- PAUSE adds exactly the paused cycle count to the next tick time.
- Outputs are all registered and change only on clk edges or on rst_n assertion.
- rst_n deasserted mid-game returns to IDLE. No move_req is issued until a new start.

## Test plan
Benches use BASE_PERIOD=16, FOOD_PER_LEVEL=2.
1. Reset, start with init_level=0, ack each req within 2 cycles. Required: move_req rises 16 cycles after start, then every 16 cycles; overrun_cnt stays 0.
2. Start with init_level=0, pulse food_eaten 4 times. Required: level steps 0→1→2. Tick spacing becomes 8 and then 4 cycles, each change applied only after the next wrap.
3. Start, never ack for 5 periods. Required: move_req stays 1 and overrun_cnt=4. Forcing 300 lost ticks leaves overrun_cnt at 255.
4. Start, pause_tgl at cnt=10, hold for 20 cycles, then pause_tgl again. Required: the next req rises 26 cycles after the pause edge; a pending req is cleared by an ack issued during PAUSE.
5. Same cycle as a tick, assert game_over. Required: state=OVER, no new move_req, move_req=0, level holds. A later start with init_level=5 gives level=5, a 16>>5=0 … clamp check; use init_level=3 and expect period 2.
6. Assert rst_n low mid-period with move_req=1. Required: move_req=0, state=IDLE and level=0 immediately, before the next clk edge.
